// File: rtl/sram_bridge_1x8_pkg.sv
// rtl/sram_bridge_1x8_pkg.sv - shared constants and types for the 1-to-8 SRAM-like bridge
package sram_bridge_1x8_pkg;

  localparam int NSLV        = 8;
  localparam int SLV_W       = 3;
  localparam int DEF_SEL_LSB = 29;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef logic [SLV_W-1:0] slv_idx_t;

endpackage

// File: rtl/sram_bridge_1x8_idx_fifo.sv
// rtl/sram_bridge_1x8_idx_fifo.sv - in-order FIFO of outstanding slave indices
module idx_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Guards keep count within 0..DEPTH even if the caller misbehaves.
  assign w_push = push && (r_count != CW'(DEPTH));
  assign w_pop  = pop  && (r_count != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/sram_bridge_1x8.sv
// rtl/sram_bridge_1x8.sv - routes one SRAM-like CPU port to eight slaves, keeping responses in order
module sram_bridge_1x8
  import sram_bridge_1x8_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int SEL_LSB = DEF_SEL_LSB
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         cpu_req,
  input  logic         cpu_wr,
  input  logic [1:0]   cpu_size,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic         cpu_addr_ok,
  output logic         cpu_data_ok,
  output logic [31:0]  cpu_rdata,
  output logic [7:0]   s_req,
  output logic         s_wr,
  output logic [1:0]   s_size,
  output logic [31:0]  s_addr,
  output logic [31:0]  s_wdata,
  input  logic [7:0]   s_addr_ok,
  input  logic [7:0]   s_data_ok,
  input  logic [255:0] s_rdata,
  output logic         err
);

  localparam int CW = $clog2(DEPTH) + 1;

  slv_idx_t      w_sel;
  slv_idx_t      w_head;
  slv_idx_t      r_last_sel;
  logic [CW-1:0] w_count;
  logic          w_busy;
  logic          w_can_issue;
  logic          w_push;
  logic [7:0]    w_head_mask;
  logic          w_bad_rsp;
  logic [31:0]   w_rd_sel;
  logic          r_err;

  assign w_sel  = cpu_addr[SEL_LSB +: SLV_W];
  assign w_busy = (w_count != '0);

  // Only the slave already being waited on may receive more requests; resetn gates
  // the combinational outputs so they read zero throughout reset.
  assign w_can_issue = resetn && (w_count < CW'(DEPTH)) && (!w_busy || (w_sel == r_last_sel));

  assign s_req       = (cpu_req && w_can_issue) ? (8'b1 << w_sel) : 8'b0;
  assign cpu_addr_ok = cpu_req && w_can_issue && s_addr_ok[w_sel];
  assign w_push      = cpu_addr_ok;

  assign s_wr    = cpu_wr;
  assign s_size  = cpu_size;
  assign s_addr  = cpu_addr;
  assign s_wdata = cpu_wdata;

  idx_fifo #(
    .WIDTH (SLV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_push),
    .pop    (cpu_data_ok),
    .din    (w_sel),
    .head   (w_head),
    .count  (w_count)
  );

  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (w_head == SLV_W'(i)) w_rd_sel = s_rdata[32*i +: 32];
    end
  end

  assign cpu_data_ok = w_busy && s_data_ok[w_head];
  assign cpu_rdata   = w_busy ? w_rd_sel : 32'h0;

  // Any response with nothing outstanding, or from a non-head slave, is a protocol error.
  assign w_head_mask = 8'b1 << w_head;
  assign w_bad_rsp   = (s_data_ok != 8'h0) && (!w_busy || ((s_data_ok & ~w_head_mask) != 8'h0));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_sel <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push)    r_last_sel <= w_sel;
      if (w_bad_rsp) r_err      <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_sram_bridge_1x8.sv
// tb/tb_sram_bridge_1x8.sv - self-checking bench for sram_bridge_1x8
module tb_sram_bridge_1x8;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         cpu_req, cpu_wr;
  logic [1:0]   cpu_size;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic         cpu_addr_ok, cpu_data_ok;
  logic [31:0]  cpu_rdata;
  logic [7:0]   s_req;
  logic         s_wr;
  logic [1:0]   s_size;
  logic [31:0]  s_addr, s_wdata;
  logic [7:0]   s_addr_ok, s_data_ok;
  logic [255:0] s_rdata;
  logic         err;

  int errors = 0;
  int checks = 0;

  sram_bridge_1x8 #(.DEPTH(DEPTH), .SEL_LSB(29)) dut (
    .clk(clk), .resetn(resetn), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_addr_ok(cpu_addr_ok),
    .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata), .s_req(s_req), .s_wr(s_wr),
    .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [7:0]  aok;
    logic [7:0]  dok;
    int          rslv;
    logic [31:0] rval;
    logic [7:0]  e_sreq;
    logic        e_aok;
    logic        e_dok;
    logic [31:0] e_rdata;
    int          e_cnt;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic [7:0] aok,
                       input logic [7:0] dok);
    cpu_req   = req;
    cpu_addr  = addr;
    s_addr_ok = aok;
    s_data_ok = dok;
  endtask

  // Background pattern per slave so a wrong head selection shows in cpu_rdata.
  task automatic set_rdata(input int slv, input logic [31:0] val);
    for (int i = 0; i < 8; i++) s_rdata[32*i +: 32] = {8{i[3:0]}};
    s_rdata[32*slv +: 32] = val;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #4;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(1'b0, 32'h0, 8'h0, 8'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  int          q[$];
  int          last_sel;
  int          pref;
  int          sel;
  logic        req, e_aok, e_dok;
  logic [7:0]  aok, dok, e_sreq;
  logic [31:0] e_rdata;
  logic        can;

  initial begin
    cpu_req = 0; cpu_wr = 0; cpu_size = 2'd2; cpu_addr = 0; cpu_wdata = 0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
    #2;
    check("reset_sreq", 32'(s_req), 32'h0);
    check("reset_addr_ok", 32'(cpu_addr_ok), 32'h0);
    check("reset_data_ok", 32'(cpu_data_ok), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_count", 32'(dut.w_count), 32'h0);

    // Single read to slave 1, slave 2 blocking slave 5, slave 4 accepting late.
    vt[0]  = '{1, 32'h2000_0010, 8'h02, 8'h00, 0, 32'h0,          8'h02, 1, 0, 32'h0,          0};
    vt[1]  = '{0, 32'h0,         8'h00, 8'h02, 1, 32'hDEAD_BEEF,  8'h00, 0, 1, 32'hDEAD_BEEF,  1};
    vt[2]  = '{0, 32'h0,         8'h00, 8'h00, 0, 32'h0,          8'h00, 0, 0, 32'h0,          0};
    vt[3]  = '{1, 32'h4000_0000, 8'h04, 8'h00, 0, 32'h0,          8'h04, 1, 0, 32'h0,          0};
    vt[4]  = '{1, 32'hA000_0000, 8'h20, 8'h00, 0, 32'h0,          8'h00, 0, 0, 32'h2222_2222,  1};
    vt[5]  = '{1, 32'hA000_0000, 8'h20, 8'h04, 2, 32'h2222_3333,  8'h00, 0, 1, 32'h2222_3333,  1};
    vt[6]  = '{1, 32'hA000_0000, 8'h20, 8'h00, 0, 32'h0,          8'h20, 1, 0, 32'h0,          0};
    vt[7]  = '{0, 32'h0,         8'h00, 8'h20, 5, 32'h5555_6666,  8'h00, 0, 1, 32'h5555_6666,  1};
    vt[8]  = '{0, 32'h0,         8'h00, 8'h00, 0, 32'h0,          8'h00, 0, 0, 32'h0,          0};
    vt[9]  = '{1, 32'h8000_0000, 8'h00, 8'h00, 0, 32'h0,          8'h10, 0, 0, 32'h0,          0};
    vt[10] = '{1, 32'h8000_0000, 8'h10, 8'h00, 0, 32'h0,          8'h10, 1, 0, 32'h0,          0};
    vt[11] = '{0, 32'h0,         8'h00, 8'h10, 4, 32'h4444_AAAA,  8'h00, 0, 1, 32'h4444_AAAA,  1};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].req, vt[i].addr, vt[i].aok, vt[i].dok);
      set_rdata(vt[i].rslv, vt[i].rval);
      sample();
      check($sformatf("vec%0d_sreq", i), 32'(s_req), 32'(vt[i].e_sreq));
      check($sformatf("vec%0d_addr_ok", i), 32'(cpu_addr_ok), 32'(vt[i].e_aok));
      check($sformatf("vec%0d_data_ok", i), 32'(cpu_data_ok), 32'(vt[i].e_dok));
      check($sformatf("vec%0d_rdata", i), cpu_rdata, vt[i].e_rdata);
      check($sformatf("vec%0d_count", i), 32'(dut.w_count), 32'(vt[i].e_cnt));
      check($sformatf("vec%0d_err", i), 32'(err), 32'h0);
      tick();
    end

    // Fill to DEPTH with slave 3, stall the fifth, free one slot, then drain.
    do_reset();
    set_rdata(3, 32'h3333_0001);
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h6000_0000, 8'h08, 8'h00);
      sample();
      check($sformatf("fill%0d_addr_ok", i), 32'(cpu_addr_ok), 32'h1);
      tick();
    end
    drive(1, 32'h6000_0000, 8'h08, 8'h00);
    sample();
    check("full_count", 32'(dut.w_count), 32'd4);
    check("full_addr_ok", 32'(cpu_addr_ok), 32'h0);
    check("full_sreq", 32'(s_req), 32'h0);
    tick();
    drive(1, 32'h6000_0000, 8'h08, 8'h08);
    sample();
    check("full_pop_data_ok", 32'(cpu_data_ok), 32'h1);
    check("full_pop_addr_ok", 32'(cpu_addr_ok), 32'h0);
    tick();
    drive(1, 32'h6000_0000, 8'h08, 8'h00);
    sample();
    check("fifth_addr_ok", 32'(cpu_addr_ok), 32'h1);
    check("fifth_sreq", 32'(s_req), 32'h08);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 8'h00, 8'h08);
      sample();
      check($sformatf("drain%0d_data_ok", i), 32'(cpu_data_ok), 32'h1);
      check($sformatf("drain%0d_rdata", i), cpu_rdata, 32'h3333_0001);
      tick();
    end
    drive(0, 32'h0, 8'h00, 8'h00);
    sample();
    check("drain_count", 32'(dut.w_count), 32'h0);
    tick();

    // Two outstanding to slave 0, then simultaneous push and pop for 8 cycles.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h0000_0100, 8'h01, 8'h00);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h0000_0100, 8'h01, 8'h01);
      set_rdata(0, 32'h0A0A_0000 + i);
      sample();
      check($sformatf("pp%0d_addr_ok", i), 32'(cpu_addr_ok), 32'h1);
      check($sformatf("pp%0d_data_ok", i), 32'(cpu_data_ok), 32'h1);
      check($sformatf("pp%0d_rdata", i), cpu_rdata, 32'h0A0A_0000 + i);
      check($sformatf("pp%0d_count", i), 32'(dut.w_count), 32'd2);
      tick();
    end
    drive(0, 32'h0, 8'h00, 8'h00);
    sample();
    check("pp_count_after", 32'(dut.w_count), 32'd2);
    tick();

    // Stray response with nothing outstanding.
    do_reset();
    drive(0, 32'h0, 8'h00, 8'h40);
    sample();
    check("stray_data_ok", 32'(cpu_data_ok), 32'h0);
    tick();
    drive(0, 32'h0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("stray_err_hold%0d", i), 32'(err), 32'h1);
      tick();
    end
    resetn = 1'b0;
    #1;
    check("stray_err_cleared", 32'(err), 32'h0);
    do_reset();

    // Response from a slave that is not at the head.
    drive(1, 32'h2000_0000, 8'h02, 8'h00);
    tick();
    drive(0, 32'h0, 8'h00, 8'h04);
    sample();
    check("wrong_head_data_ok", 32'(cpu_data_ok), 32'h0);
    tick();
    drive(0, 32'h0, 8'h00, 8'h00);
    sample();
    check("wrong_head_err", 32'(err), 32'h1);
    check("wrong_head_count", 32'(dut.w_count), 32'h1);
    tick();

    // Asynchronous reset with three entries outstanding, then a stale response.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hE000_0000, 8'h80, 8'h00);
      tick();
    end
    drive(1, 32'hE000_0000, 8'h80, 8'h80);
    set_rdata(7, 32'h7777_7777);
    #2;
    check("pre_reset_count", 32'(dut.w_count), 32'd3);
    resetn = 1'b0;
    #1;
    check("async_count", 32'(dut.w_count), 32'h0);
    check("async_sreq", 32'(s_req), 32'h0);
    check("async_addr_ok", 32'(cpu_addr_ok), 32'h0);
    check("async_data_ok", 32'(cpu_data_ok), 32'h0);
    check("async_rdata", cpu_rdata, 32'h0);
    check("async_err", 32'(err), 32'h0);
    drive(0, 32'h0, 8'h00, 8'h00);
    tick();
    resetn = 1'b1;
    drive(0, 32'h0, 8'h00, 8'h80);
    sample();
    check("stale_data_ok", 32'(cpu_data_ok), 32'h0);
    tick();
    drive(0, 32'h0, 8'h00, 8'h00);
    sample();
    check("stale_err", 32'(err), 32'h1);
    tick();

    // Randomised traffic against a queue model of outstanding slave indices.
    do_reset();
    q.delete();
    last_sel = 0;
    pref = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) pref = $urandom_range(0, 7);
      req = ($urandom_range(0, 3) != 0);
      sel = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : pref;
      aok = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      dok = 8'h0;
      if (q.size() != 0 && $urandom_range(0, 2) == 0) dok = 8'h1 << q[0];
      cpu_wr    = $urandom_range(0, 1) != 0;
      cpu_wdata = $urandom;
      for (int i = 0; i < 8; i++) s_rdata[32*i +: 32] = $urandom;
      drive(req, {sel[2:0], 29'($urandom)}, aok, dok);

      can     = (q.size() < DEPTH) && (q.size() == 0 || sel == last_sel);
      e_sreq  = (req && can) ? (8'h1 << sel) : 8'h0;
      e_aok   = req && can && aok[sel];
      e_dok   = (q.size() != 0) && dok[q[0]];
      e_rdata = (q.size() != 0) ? s_rdata[32*q[0] +: 32] : 32'h0;

      sample();
      check("rnd_sreq", 32'(s_req), 32'(e_sreq));
      check("rnd_addr_ok", 32'(cpu_addr_ok), 32'(e_aok));
      check("rnd_data_ok", 32'(cpu_data_ok), 32'(e_dok));
      check("rnd_rdata", cpu_rdata, e_rdata);
      check("rnd_count", 32'(dut.w_count), 32'(q.size()));
      check("rnd_bcast_addr", s_addr, cpu_addr);
      check("rnd_bcast_wr", 32'(s_wr), 32'(cpu_wr));
      check("rnd_err", 32'(err), 32'h0);
      tick();

      if (e_dok) void'(q.pop_front());
      if (e_aok) begin
        q.push_back(sel);
        last_sel = sel;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
